sparse_mac_pe: RTL and testbench
================================

SPARSE_MAC_PE -- requirements
Module: sparse_mac_pe

Interface
REQ-001 Parameter DATA_W, default 16: signed IA/weight operand width and output width.
REQ-002 Parameter IDX_W, default 8: channel index width.
REQ-003 Parameter IA_LEN, default 32: max IA nonzeros per fiber.
REQ-004 Parameter OUT_DEPTH, default 48: accumulator entries; ADDR_W = clog2(OUT_DEPTH).
REQ-005 Parameter ACC_W, default 40: signed accumulator width.
REQ-006 i_clk  in  1  clock; single clock domain.
REQ-007 i_rst  in  1  reset; asynchronous, active-high.
REQ-008 i_start  in  1  pulse; latches IA fiber and pass controls.
REQ-009 i_clear  in  1  sampled with i_start; 1 zeroes accumulators, 0 keeps them.
REQ-010 i_ia_len  in  clog2(IA_LEN)+1  valid IA entries.
REQ-011 i_ia_data / i_ia_idx  in  IA_LEN x DATA_W / IA_LEN x IDX_W  IA values and channel indices.
REQ-012 i_shift  in  5  output arithmetic right shift, sampled with i_start.
REQ-013 i_w_valid / o_w_ready  in/out  1/1  weight stream handshake.
REQ-014 i_w_data / i_w_idx / i_w_addr / i_w_last  in  DATA_W / IDX_W / ADDR_W / 1  weight value, channel, accumulator address, final beat.
REQ-015 o_out_valid / i_out_ready  out/in  1/1  result stream handshake.
REQ-016 o_out_data / o_out_addr / o_out_last  out  DATA_W / ADDR_W / 1  result, its address, final entry.
REQ-017 o_busy  out  1  high when not IDLE.
REQ-018 o_finish  out  1  one-cycle pulse at pass end.
REQ-019 o_match_cnt  out  16  matched weight beats this pass.

Function
REQ-020 States: IDLE, MAC, DRAIN, DUMP; i_start honoured only in IDLE.
REQ-021 IDLE + i_start: latch IA arrays, len (values > IA_LEN clamp to IA_LEN), shift; i_clear=1 zeroes all accumulators; o_match_cnt <= 0; -> MAC next cycle.
REQ-022 MAC: o_w_ready=1; beat accepted on i_w_valid & o_w_ready.
REQ-023 Stage 1 (registered): compare i_w_idx with i_ia_idx[0..len-1]; hit = any equal; lowest matching entry wins on duplicates.
REQ-024 Stage 2 (registered): full-precision signed product, 2*DATA_W bits.
REQ-025 Stage 3: on hit, acc[addr] += sign-extended product, wraps modulo 2^ACC_W; o_match_cnt increments (saturating at 65535).
REQ-026 Latency: accepted beat updates its accumulator at the 3rd rising edge after acceptance.
REQ-027 Read-modify-write completes in one cycle; back-to-back beats to the same address lose no update.
REQ-028 Beats with i_w_addr >= OUT_DEPTH: no write, not counted.
REQ-029 len=0: no beat hits.
REQ-030 Accepted beat with i_w_last: -> DRAIN; o_w_ready low from the next cycle.
REQ-031 DRAIN: wait until stages 1-3 are empty, then -> DUMP.
REQ-032 DUMP: emit entries 0..OUT_DEPTH-1 in order; o_out_data = (acc >>> shift) saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; o_out_last on entry OUT_DEPTH-1.
REQ-033 Output fields held stable while o_out_valid & !i_out_ready; no entry skipped or repeated.
REQ-034 Handshake of last entry: -> IDLE, o_finish=1 for that following cycle.
REQ-035 Accumulators are not cleared by DUMP; a pass started with i_clear=0 accumulates onto prior results.

Reset
REQ-036 i_rst: state IDLE; accumulators, pipeline valids, o_match_cnt zeroed; o_w_ready, o_out_valid, o_out_last, o_busy, o_finish, o_out_data, o_out_addr all 0.
REQ-037 Reset mid-pass aborts immediately; no o_finish; no partial result emitted.

Verification
REQ-038 len=3, idx {2,5,9}, data {3,-4,7}, clear=1, shift=0; beats (5,2,a0),(9,-1,a0),(4,8,a1,last) -> a0=-15, all others 0, o_match_cnt=2, single o_finish.
REQ-039 Ten consecutive beats, product 100 each, addr 7 -> a7=1000.
REQ-040 One beat 32767*32767 at a3: shift=0 -> 32767 (saturated); shift=15 -> 32766.
REQ-041 Pass1 clear=1 gives a2=50; pass2 clear=0 adds 25 -> a2=75; pass3 clear=1 with no hits -> a2=0.
REQ-042 Random i_w_valid gaps and i_out_ready held low 5 cycles mid-dump -> output stable, 48 entries exactly once each, results match model.
REQ-043 i_rst asserted after 4 accepted beats -> all outputs 0 next edge, no o_finish; following pass with clear=0 dumps all zeros.

Source files
------------

// File: rtl/sparse_mac_pe.sv
// ============================================================================
// sparse_mac_pe
//
// Sparse multiply-accumulate processing element. A pass starts by latching an
// input-activation (IA) fiber: up to IA_LEN nonzero values with their channel
// indices. A stream of weight beats then follows. Each beat carries a value, a
// channel index and an accumulator address. A beat whose channel matches a
// latched IA entry adds (ia * weight) into acc[addr]. After the final beat the
// pipeline drains. The accumulators are then dumped in address order, each
// scaled by an arithmetic right shift and saturated to DATA_W bits.
//
// Pipeline for one accepted beat:
//   accept edge : channel compare result registered (stage 1)
//   next edge   : full-precision signed product registered (stage 2)
//   next edge   : acc[addr] read-modify-write in a single cycle (stage 3)
//
// Ports
//   i_clk, i_rst            clock; asynchronous active-high reset
//   i_start, i_clear        start a pass (IDLE only); clear accumulators first
//   i_ia_len                number of valid IA entries (clamped to IA_LEN)
//   i_ia_data, i_ia_idx     IA values / channel indices, latched on i_start
//   i_shift                 output arithmetic right shift, latched on i_start
//   i_w_valid, o_w_ready    weight stream handshake
//   i_w_data, i_w_idx       weight value and channel
//   i_w_addr, i_w_last      accumulator address; final beat of the pass
//   o_out_valid, i_out_ready  result stream handshake
//   o_out_data, o_out_addr  scaled/saturated result and its address
//   o_out_last              marks entry OUT_DEPTH-1
//   o_busy                  high whenever the FSM is not IDLE
//   o_finish                one-cycle pulse after the last result handshake
//   o_match_cnt             matched, in-range beats this pass (saturating)
// ============================================================================
module sparse_mac_pe #(
    parameter  int DATA_W    = 16,
    parameter  int IDX_W     = 8,
    parameter  int IA_LEN    = 32,
    parameter  int OUT_DEPTH = 48,
    parameter  int ACC_W     = 40,
    localparam int ADDR_W    = $clog2(OUT_DEPTH),
    localparam int LEN_W     = $clog2(IA_LEN) + 1
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_start,
    input  logic                           i_clear,
    input  logic [LEN_W-1:0]               i_ia_len,
    input  logic [IA_LEN-1:0][DATA_W-1:0]  i_ia_data,
    input  logic [IA_LEN-1:0][IDX_W-1:0]   i_ia_idx,
    input  logic [4:0]                     i_shift,
    input  logic                           i_w_valid,
    output logic                           o_w_ready,
    input  logic [DATA_W-1:0]              i_w_data,
    input  logic [IDX_W-1:0]               i_w_idx,
    input  logic [ADDR_W-1:0]              i_w_addr,
    input  logic                           i_w_last,
    output logic                           o_out_valid,
    input  logic                           i_out_ready,
    output logic [DATA_W-1:0]              o_out_data,
    output logic [ADDR_W-1:0]              o_out_addr,
    output logic                           o_out_last,
    output logic                           o_busy,
    output logic                           o_finish,
    output logic [15:0]                    o_match_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_DRAIN,
        S_DUMP
    } state_t;

    // Saturation bounds of a DATA_W signed result, held at accumulator width.
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    state_t                          state;

    // Latched pass context
    logic [IA_LEN-1:0][DATA_W-1:0]   ia_data_q;
    logic [IA_LEN-1:0][IDX_W-1:0]    ia_idx_q;
    logic [LEN_W-1:0]                ia_len_q;
    logic [4:0]                      shift_q;

    // Pipeline registers
    logic                            s1_valid;
    logic                            s1_hit;
    logic signed [DATA_W-1:0]        s1_ia;
    logic signed [DATA_W-1:0]        s1_w;
    logic [ADDR_W-1:0]               s1_addr;
    logic                            s2_valid;
    logic                            s2_hit;
    logic signed [2*DATA_W-1:0]      s2_prod;
    logic [ADDR_W-1:0]               s2_addr;

    logic signed [ACC_W-1:0]         acc [OUT_DEPTH];

    logic                            start_fire;
    logic                            w_fire;
    logic                            cmp_hit;
    logic [DATA_W-1:0]               cmp_ia;
    logic                            addr_ok;
    logic [ADDR_W-1:0]               dump_next;

    assign start_fire = i_start && (state == S_IDLE);
    assign w_fire     = i_w_valid && o_w_ready;
    assign addr_ok    = {1'b0, i_w_addr} < (ADDR_W+1)'(OUT_DEPTH);
    assign dump_next  = o_out_addr + ADDR_W'(1);

    // Arithmetic right shift followed by clamping into the DATA_W signed range.
    function automatic logic [DATA_W-1:0] scale_sat(
        input logic signed [ACC_W-1:0] v,
        input logic [4:0]              sh
    );
        logic signed [ACC_W-1:0] s;
        s = v >>> sh;
        if (s > SAT_MAX)
            return SAT_MAX[DATA_W-1:0];
        else if (s < SAT_MIN)
            return SAT_MIN[DATA_W-1:0];
        else
            return s[DATA_W-1:0];
    endfunction

    // Channel match against the latched fiber. The scan runs from the top
    // entry down, so the lowest matching entry is the one that sticks.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch;
        // a path that leaves one unassigned would infer a latch.
        cmp_hit = 1'b0;
        cmp_ia  = '0;
        for (int k = IA_LEN - 1; k >= 0; k--) begin
            if ((LEN_W'(k) < ia_len_q) && (ia_idx_q[k] == i_w_idx)) begin
                cmp_hit = 1'b1;
                cmp_ia  = ia_data_q[k];
            end
        end
    end

    // Stages 1 and 2. Out-of-range addresses are folded into the hit flag so
    // that they neither write nor count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        // NOTE: sequential state always uses non-blocking assignments so that
        // every register samples pre-edge values, independent of block order.
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_hit   <= 1'b0;
            s1_ia    <= '0;
            s1_w     <= '0;
            s1_addr  <= '0;
            s2_valid <= 1'b0;
            s2_hit   <= 1'b0;
            s2_prod  <= '0;
            s2_addr  <= '0;
        end else begin
            s1_valid <= w_fire;
            if (w_fire) begin
                s1_hit  <= cmp_hit && addr_ok;
                s1_ia   <= cmp_ia;
                s1_w    <= i_w_data;
                s1_addr <= i_w_addr;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_hit  <= s1_hit;
                s2_prod <= s1_ia * s1_w;
                s2_addr <= s1_addr;
            end
        end
    end

    // Stage 3: the read and the write of acc[addr] happen in the same cycle,
    // so consecutive beats to one address chain correctly without forwarding.
    always_ff @(posedge i_clk or posedge i_rst) begin
        // NOTE: the accumulators must read as zero straight out of reset, so
        // they are built as resettable flops rather than an unreset RAM.
        if (i_rst) begin
            for (int i = 0; i < OUT_DEPTH; i++)
                acc[i] <= '0;
        end else if (start_fire && i_clear) begin
            for (int i = 0; i < OUT_DEPTH; i++)
                acc[i] <= '0;
        end else if (s2_valid && s2_hit) begin
            acc[s2_addr] <= acc[s2_addr] + ACC_W'(s2_prod);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_match_cnt <= '0;
        end else if (start_fire) begin
            o_match_cnt <= '0;
        end else if (s2_valid && s2_hit && (o_match_cnt != 16'hFFFF)) begin
            o_match_cnt <= o_match_cnt + 16'd1;
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= S_IDLE;
            ia_data_q   <= '0;
            ia_idx_q    <= '0;
            ia_len_q    <= '0;
            shift_q     <= '0;
            o_w_ready   <= 1'b0;
            o_out_valid <= 1'b0;
            o_out_last  <= 1'b0;
            o_out_data  <= '0;
            o_out_addr  <= '0;
            o_busy      <= 1'b0;
            o_finish    <= 1'b0;
        end else begin
            o_finish <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        ia_data_q <= i_ia_data;
                        ia_idx_q  <= i_ia_idx;
                        ia_len_q  <= (i_ia_len > LEN_W'(IA_LEN)) ? LEN_W'(IA_LEN) : i_ia_len;
                        shift_q   <= i_shift;
                        o_busy    <= 1'b1;
                        o_w_ready <= 1'b1;
                        state     <= S_MAC;
                    end
                end
                S_MAC: begin
                    if (w_fire && i_w_last) begin
                        o_w_ready <= 1'b0;
                        state     <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Stage 3 has written by the time both valids are low.
                    if (!s1_valid && !s2_valid) begin
                        o_out_valid <= 1'b1;
                        o_out_addr  <= '0;
                        o_out_data  <= scale_sat(acc[0], shift_q);
                        o_out_last  <= (OUT_DEPTH == 1);
                        state       <= S_DUMP;
                    end
                end
                S_DUMP: begin
                    // o_out_valid is high throughout DUMP; fields hold until taken.
                    if (i_out_ready) begin
                        if (o_out_last) begin
                            o_out_valid <= 1'b0;
                            o_out_last  <= 1'b0;
                            o_busy      <= 1'b0;
                            o_finish    <= 1'b1;
                            state       <= S_IDLE;
                        end else begin
                            o_out_addr <= dump_next;
                            o_out_data <= scale_sat(acc[dump_next], shift_q);
                            o_out_last <= (dump_next == ADDR_W'(OUT_DEPTH - 1));
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sparse_mac_pe.sv
// ============================================================================
// tb_sparse_mac_pe
//
// Directed and randomized passes through sparse_mac_pe. Expected results come
// from a pass-level reference model: per beat, search the fiber for the first
// matching channel, add ia*w into an integer accumulator (wrapped to 40 bits),
// then scale and saturate the accumulators at dump time.
// ============================================================================
module tb_sparse_mac_pe;

    localparam int DATA_W    = 16;
    localparam int IDX_W     = 8;
    localparam int IA_LEN    = 32;
    localparam int OUT_DEPTH = 48;
    localparam int ACC_W     = 40;
    localparam int ADDR_W    = 6;
    localparam int LEN_W     = 6;

    logic                           i_clk;
    logic                           i_rst;
    logic                           i_start;
    logic                           i_clear;
    logic [LEN_W-1:0]               i_ia_len;
    logic [IA_LEN-1:0][DATA_W-1:0]  i_ia_data;
    logic [IA_LEN-1:0][IDX_W-1:0]   i_ia_idx;
    logic [4:0]                     i_shift;
    logic                           i_w_valid;
    logic                           o_w_ready;
    logic [DATA_W-1:0]              i_w_data;
    logic [IDX_W-1:0]               i_w_idx;
    logic [ADDR_W-1:0]              i_w_addr;
    logic                           i_w_last;
    logic                           o_out_valid;
    logic                           i_out_ready;
    logic [DATA_W-1:0]              o_out_data;
    logic [ADDR_W-1:0]              o_out_addr;
    logic                           o_out_last;
    logic                           o_busy;
    logic                           o_finish;
    logic [15:0]                    o_match_cnt;

    sparse_mac_pe #(
        .DATA_W   (DATA_W),
        .IDX_W    (IDX_W),
        .IA_LEN   (IA_LEN),
        .OUT_DEPTH(OUT_DEPTH),
        .ACC_W    (ACC_W)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_clear     (i_clear),
        .i_ia_len    (i_ia_len),
        .i_ia_data   (i_ia_data),
        .i_ia_idx    (i_ia_idx),
        .i_shift     (i_shift),
        .i_w_valid   (i_w_valid),
        .o_w_ready   (o_w_ready),
        .i_w_data    (i_w_data),
        .i_w_idx     (i_w_idx),
        .i_w_addr    (i_w_addr),
        .i_w_last    (i_w_last),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_data  (o_out_data),
        .o_out_addr  (o_out_addr),
        .o_out_last  (o_out_last),
        .o_busy      (o_busy),
        .o_finish    (o_finish),
        .o_match_cnt (o_match_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int finish_cnt = 0;
    int exp_finish = 0;

    always @(negedge i_clk) if (o_finish === 1'b1) finish_cnt++;

    // Reference model state
    longint m_acc [OUT_DEPTH];
    int     m_ia_idx [IA_LEN];
    int     m_ia_data [IA_LEN];
    int     m_len;
    int     m_shift;
    int     m_match;

    logic signed [63:0] dump_got [OUT_DEPTH];

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint wrap_acc(input longint v);
        return (v <<< (64 - ACC_W)) >>> (64 - ACC_W);
    endfunction

    function automatic longint exp_out(input int a);
        longint v;
        v = m_acc[a] >>> m_shift;
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic model_beat(input int idx, input int data, input int addr);
        if (addr >= OUT_DEPTH) return;
        for (int j = 0; j < m_len; j++) begin
            if (m_ia_idx[j] == idx) begin
                m_acc[addr] = wrap_acc(m_acc[addr] + longint'(m_ia_data[j]) * longint'(data));
                if (m_match < 65535) m_match++;
                return;
            end
        end
    endtask

    task automatic clear_ia();
        for (int j = 0; j < IA_LEN; j++) begin
            m_ia_idx[j]  = 255;
            m_ia_data[j] = 0;
        end
    endtask

    task automatic start_pass(input int len, input int shift, input bit clear);
        m_len   = (len > IA_LEN) ? IA_LEN : len;
        m_shift = shift;
        m_match = 0;
        if (clear)
            for (int a = 0; a < OUT_DEPTH; a++) m_acc[a] = 0;
        @(negedge i_clk);
        for (int j = 0; j < IA_LEN; j++) begin
            i_ia_idx[j]  = IDX_W'(m_ia_idx[j]);
            i_ia_data[j] = DATA_W'(m_ia_data[j]);
        end
        i_ia_len = LEN_W'(len);
        i_shift  = 5'(shift);
        i_clear  = clear;
        i_start  = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        i_clear = 1'b0;
        check("busy_after_start", o_busy, 1);
        check("w_ready_after_start", o_w_ready, 1);
        check("match_cnt_at_start", o_match_cnt, 0);
    endtask

    task automatic send_beat(input int idx, input int data, input int addr,
                             input bit last, input int gap);
        int waited;
        for (int g = 0; g < gap; g++) begin
            @(negedge i_clk);
            i_w_valid = 1'b0;
        end
        @(negedge i_clk);
        i_w_valid = 1'b1;
        i_w_idx   = IDX_W'(idx);
        i_w_data  = DATA_W'(data);
        i_w_addr  = ADDR_W'(addr);
        i_w_last  = last;
        waited = 0;
        while (o_w_ready !== 1'b1 && waited < 20) begin
            @(negedge i_clk);
            waited++;
        end
        if (o_w_ready !== 1'b1) begin
            check("w_ready_wait", o_w_ready, 1);
            i_w_valid = 1'b0;
            return;
        end
        model_beat(idx, data, addr);
        @(posedge i_clk);
    endtask

    task automatic end_beats();
        @(negedge i_clk);
        i_w_valid = 1'b0;
        i_w_last  = 1'b0;
    endtask

    task automatic run_dump(input bit stall);
        int got = 0;
        int cycles = 0;
        int stall_left = 0;
        bit stall_done = 0;
        bit stalled = 0;
        logic [ADDR_W-1:0] snap_addr;
        logic [DATA_W-1:0] snap_data;
        logic              snap_last;
        i_out_ready = 1'b0;
        while (got < OUT_DEPTH && cycles < 1000) begin
            @(negedge i_clk);
            cycles++;
            if (stalled) begin
                check("hold_valid", o_out_valid, 1);
                check("hold_addr", o_out_addr, snap_addr);
                check("hold_data", $signed(o_out_data), $signed(snap_data));
                check("hold_last", o_out_last, snap_last);
            end
            stalled = 0;
            if (o_out_valid === 1'b1) begin
                if (stall && got == 20 && !stall_done) begin
                    stall_left = 5;
                    stall_done = 1;
                end
                if (stall_left > 0) begin
                    i_out_ready = 1'b0;
                    stall_left--;
                end else if (stall) begin
                    i_out_ready = ($urandom_range(0, 3) != 0);
                end else begin
                    i_out_ready = 1'b1;
                end
                if (i_out_ready) begin
                    check("out_addr", o_out_addr, got);
                    check("out_data", $signed(o_out_data), exp_out(got));
                    check("out_last", o_out_last, (got == OUT_DEPTH - 1));
                    dump_got[got] = $signed(o_out_data);
                    got++;
                end else begin
                    stalled   = 1;
                    snap_addr = o_out_addr;
                    snap_data = o_out_data;
                    snap_last = o_out_last;
                end
            end else begin
                i_out_ready = 1'b0;
            end
        end
        check("dump_count", got, OUT_DEPTH);
        @(negedge i_clk);
        i_out_ready = 1'b0;
        exp_finish++;
        check("finish_pulse", o_finish, 1);
        check("valid_after_dump", o_out_valid, 0);
        check("busy_after_dump", o_busy, 0);
        check("match_cnt", o_match_cnt, m_match);
        @(negedge i_clk);
        check("finish_one_cycle", o_finish, 0);
        check("finish_count", finish_cnt, exp_finish);
    endtask

    task automatic random_pass(input bit stall, input bit clear);
        int len;
        int nbeats;
        clear_ia();
        len = $urandom_range(0, 40);
        for (int j = 0; j < IA_LEN; j++) begin
            m_ia_idx[j]  = $urandom_range(0, 15);
            m_ia_data[j] = int'($urandom_range(0, 65535)) - 32768;
        end
        start_pass(len, $urandom_range(0, 12), clear);
        nbeats = $urandom_range(15, 40);
        for (int b = 0; b < nbeats; b++)
            send_beat($urandom_range(0, 20), int'($urandom_range(0, 65535)) - 32768,
                      $urandom_range(0, 55), (b == nbeats - 1), $urandom_range(0, 3));
        end_beats();
        run_dump(stall);
    endtask

    initial begin
        #(100000 * 10);
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_clear = 1'b0; i_ia_len = '0;
        i_ia_data = '0; i_ia_idx = '0; i_shift = '0; i_w_valid = 1'b0;
        i_w_data = '0; i_w_idx = '0; i_w_addr = '0; i_w_last = 1'b0;
        i_out_ready = 1'b0;
        for (int a = 0; a < OUT_DEPTH; a++) m_acc[a] = 0;
        clear_ia();

        // Reset state
        @(negedge i_clk);
        check("rst_w_ready", o_w_ready, 0);
        check("rst_out_valid", o_out_valid, 0);
        check("rst_out_last", o_out_last, 0);
        check("rst_busy", o_busy, 0);
        check("rst_finish", o_finish, 0);
        check("rst_out_data", o_out_data, 0);
        check("rst_out_addr", o_out_addr, 0);
        check("rst_match_cnt", o_match_cnt, 0);
        @(negedge i_clk);
        i_rst = 1'b0;

        // Basic sparse match: a0 = -4*2 + 7*-1 = -15, idx 4 misses
        clear_ia();
        m_ia_idx[0] = 2; m_ia_data[0] = 3;
        m_ia_idx[1] = 5; m_ia_data[1] = -4;
        m_ia_idx[2] = 9; m_ia_data[2] = 7;
        start_pass(3, 0, 1);
        send_beat(5, 2, 0, 0, 0);
        send_beat(9, -1, 0, 0, 1);
        send_beat(4, 8, 1, 1, 0);
        end_beats();
        run_dump(0);
        check("basic_a0", dump_got[0], -15);
        check("basic_a1", dump_got[1], 0);
        check("basic_match", o_match_cnt, 2);
        check("basic_finish_total", finish_cnt, 1);

        // Ten back-to-back beats into the same accumulator
        clear_ia();
        m_ia_idx[0] = 1; m_ia_data[0] = 10;
        start_pass(1, 0, 1);
        for (int b = 0; b < 10; b++) send_beat(1, 10, 7, (b == 9), 0);
        end_beats();
        run_dump(0);
        check("b2b_a7", dump_got[7], 1000);

        // Full-scale product: saturation, then shift by 15
        clear_ia();
        m_ia_idx[0] = 3; m_ia_data[0] = 32767;
        start_pass(1, 0, 1);
        send_beat(3, 32767, 3, 1, 0);
        end_beats();
        run_dump(0);
        check("sat_shift0", dump_got[3], 32767);
        start_pass(1, 15, 1);
        send_beat(3, 32767, 3, 1, 0);
        end_beats();
        run_dump(0);
        check("sat_shift15", dump_got[3], 32766);

        // Accumulate across passes, then clear
        clear_ia();
        m_ia_idx[0] = 2; m_ia_data[0] = 5;
        start_pass(1, 0, 1);
        send_beat(2, 10, 2, 1, 0);
        end_beats();
        run_dump(0);
        check("keep_pass1", dump_got[2], 50);
        start_pass(1, 0, 0);
        send_beat(2, 5, 2, 1, 0);
        end_beats();
        run_dump(0);
        check("keep_pass2", dump_got[2], 75);
        start_pass(1, 0, 1);
        send_beat(7, 1, 2, 1, 0);
        end_beats();
        run_dump(0);
        check("keep_pass3", dump_got[2], 0);

        // Duplicate channels (lowest entry wins), out-of-range address, len clamp
        clear_ia();
        m_ia_idx[0] = 4;  m_ia_data[0] = 2;
        m_ia_idx[1] = 4;  m_ia_data[1] = 3;
        m_ia_idx[31] = 77; m_ia_data[31] = 6;
        start_pass(40, 0, 1);
        send_beat(4, 1, 5, 0, 0);
        send_beat(4, 9, 50, 0, 0);
        send_beat(77, 1, 10, 1, 0);
        end_beats();
        run_dump(0);
        check("dup_lowest", dump_got[5], 2);
        check("clamp_last_entry", dump_got[10], 6);
        check("oob_not_counted", o_match_cnt, 2);

        // len = 0: nothing can hit
        clear_ia();
        m_ia_idx[0] = 3; m_ia_data[0] = 9;
        start_pass(0, 0, 1);
        send_beat(3, 5, 1, 1, 0);
        end_beats();
        run_dump(0);
        check("len0_a1", dump_got[1], 0);
        check("len0_match", o_match_cnt, 0);

        // Randomized passes, with output backpressure and a 5-cycle stall
        random_pass(1, 1);
        random_pass(1, 0);
        random_pass(0, 0);
        random_pass(1, 1);

        // Reset mid-pass after four accepted beats
        clear_ia();
        m_ia_idx[0] = 1; m_ia_data[0] = 2;
        start_pass(1, 0, 1);
        for (int b = 0; b < 4; b++) send_beat(1, 3, b, 0, 0);
        @(negedge i_clk);
        i_w_valid = 1'b0;
        i_rst = 1'b1;
        @(negedge i_clk);
        check("midrst_w_ready", o_w_ready, 0);
        check("midrst_out_valid", o_out_valid, 0);
        check("midrst_out_last", o_out_last, 0);
        check("midrst_busy", o_busy, 0);
        check("midrst_finish", o_finish, 0);
        check("midrst_out_data", o_out_data, 0);
        check("midrst_out_addr", o_out_addr, 0);
        check("midrst_match_cnt", o_match_cnt, 0);
        i_rst = 1'b0;
        for (int a = 0; a < OUT_DEPTH; a++) m_acc[a] = 0;
        repeat (5) @(negedge i_clk);
        check("midrst_no_finish", finish_cnt, exp_finish);
        start_pass(1, 0, 0);
        send_beat(9, 4, 0, 1, 0);
        end_beats();
        run_dump(0);
        for (int a = 0; a < 4; a++) check("midrst_zero", dump_got[a], 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
